// File: rtl/ad7991_pkg.sv
// Shared definitions for the AD7991 I2C target emulation: FSM states,
// default address, config/result field positions and channel helpers.
package ad7991_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [6:0] AD7991_ADDR_DEFAULT = 7'h28;

    // Channel-enable field inside the config byte (CH3..CH0 at [7:4]).
    localparam int CFG_CH_LSB = 4;
    localparam int CFG_CH_MSB = 7;

    // 16-bit conversion result: {2'b00, channel id, 12-bit data}.
    localparam int RES_CH_LSB   = 12;
    localparam int RES_CH_MSB   = 13;
    localparam int RES_DATA_MSB = 11;

    // Lowest enabled channel; channel 0 when nothing is enabled.
    function automatic logic [1:0] lowest_channel(input logic [3:0] en);
        logic [1:0] low;
        low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) low = 2'(i);
        end
        return low;
    endfunction

    // Next enabled channel strictly after cur, wrapping 3->0; channel 0 when none.
    function automatic logic [1:0] next_channel(input logic [1:0] cur, input logic [3:0] en);
        logic [1:0] nxt;
        logic [1:0] cand;
        logic       found;
        nxt   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = cur + 2'(i);
            if (!found && en[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    // Build the AD7991 result word for one channel of the packed sample bus.
    function automatic logic [15:0] make_result(input logic [1:0] ch, input logic [47:0] samples);
        logic [11:0] d;
        logic [15:0] res;
        case (ch)
            2'd0: d = samples[11:0];
            2'd1: d = samples[23:12];
            2'd2: d = samples[35:24];
            2'd3: d = samples[47:36];
        endcase
        res = '0;
        res[RES_CH_MSB:RES_CH_LSB] = ch;
        res[RES_DATA_MSB:0]        = d;
        return res;
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Input conditioning for one I2C line: synchroniser, optional glitch filter
// (I2C_GLITCH_FILTER_EN) and registered rise/fall detection.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
`ifdef I2C_GLITCH_FILTER_EN
    , parameter int FILTER_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   clean;
    logic                   clean_q;

    // Metastability synchroniser; an idle I2C line is high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking keeps every stage sampling the previous stage's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    // Accept a new line level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt    <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q[SYNC_STAGES-1];
`endif

    // Registered edge detect; level is the value the edges were taken against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            clean_q <= clean;
            rise    <= clean & ~clean_q;
            fall    <= ~clean & clean_q;
        end
    end

    assign level = clean_q;

endmodule

// File: rtl/ad7991_i2c_target.sv
// AD7991 I2C target emulation: address/config decoding and 2-byte conversion
// reads served from sample_data, open-drain SDA through sda_oe.
// Optional glitch filter on SCL/SDA enabled by defining I2C_GLITCH_FILTER_EN.
module ad7991_i2c_target
    import ad7991_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = AD7991_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2,
`ifdef I2C_GLITCH_FILTER_EN
    parameter int         FILTER_LEN  = 3,
`endif
    parameter logic [7:0] CFG_RESET   = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [47:0] sample_data,
    output logic [7:0]  config_out,
    output logic        cfg_wr_pulse,
    output logic        rd_pulse,
    output logic        busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_GLITCH_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_scl_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (scl_i),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_GLITCH_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_sda_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sda_i),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic        rw;
    logic        ack_phase;   // 1 once SCL has risen inside an ACK bit
    logic        byte_sel;    // 0 = result byte 0 in flight, 1 = byte 1
    logic [1:0]  ch_ptr;
    logic [15:0] result;

    logic        start_evt;
    logic        stop_evt;
    logic [7:0]  cur_byte;
    logic [1:0]  next_ch;
    logic [3:0]  ch_en;

    assign start_evt = sda_fall & scl_level;
    assign stop_evt  = sda_rise & scl_level;
    assign cur_byte  = byte_sel ? result[7:0] : result[15:8];
    assign ch_en     = config_out[CFG_CH_MSB:CFG_CH_LSB];
    assign next_ch   = next_channel(ch_ptr, ch_en);

    // Protocol FSM: bus conditions first, then per-state bit handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sda_oe       <= 1'b0;
            config_out   <= CFG_RESET;
            cfg_wr_pulse <= 1'b0;
            rd_pulse     <= 1'b0;
            busy         <= 1'b0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            rw           <= 1'b0;
            ack_phase    <= 1'b0;
            byte_sel     <= 1'b0;
            ch_ptr       <= 2'd0;
            result       <= '0;
        end else begin
            cfg_wr_pulse <= 1'b0;
            rd_pulse     <= 1'b0;
            if (stop_evt) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_evt) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[5:0], sda_level};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_q == I2C_ADDR) begin
                                    state     <= ST_ADDR_ACK;
                                    rw        <= sda_level;
                                    busy      <= 1'b1;
                                    ack_phase <= 1'b0;
                                end else begin
                                    state <= ST_IGNORE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (state == ST_ADDR_ACK && rw) begin
                                    state    <= ST_RD_DATA;
                                    byte_sel <= 1'b0;
                                    sda_oe   <= ~result[15];
                                end else begin
                                    state  <= ST_WR_DATA;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end else if (scl_rise) begin
                            ack_phase <= 1'b1;
                            if (state == ST_ADDR_ACK && rw) result <= make_result(ch_ptr, sample_data);
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[5:0], sda_level};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                config_out   <= {shift_q, sda_level};
                                cfg_wr_pulse <= 1'b1;
                                ch_ptr       <= lowest_channel(shift_q[6:3]);
                                state        <= ST_WR_ACK;
                                ack_phase    <= 1'b0;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                state     <= ST_RD_ACK;
                                ack_phase <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sda_oe  <= ~cur_byte[3'd6 - bit_cnt];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && !ack_phase) begin
                            if (!sda_level) begin
                                ack_phase <= 1'b1;
                                if (!byte_sel) begin
                                    byte_sel <= 1'b1;
                                end else begin
                                    rd_pulse <= 1'b1;
                                    byte_sel <= 1'b0;
                                    ch_ptr   <= next_ch;
                                    result   <= make_result(next_ch, sample_data);
                                end
                            end else begin
                                rd_pulse <= byte_sel;
                                state    <= ST_IGNORE;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ST_RD_DATA;
                            sda_oe    <= ~cur_byte[7];
                        end
                    end
                    default: begin
                        // IDLE and IGNORE: wait for a bus condition with SDA released.
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
